mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS control/datapath.
- Serves instruction fetches, LW and SW requests that the control FSM issues through its memory port (address from the IorD mux, plus a wr strobe).
- Provides word-addressed storage with a fixed, parameterised read latency, which the control FSM's fetch delay states are sized against.
- Returns read data with a one-cycle valid pulse and flags illegal accesses.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored. Must be a power of 2.
- RD_LATENCY, 2: cycles from read acceptance to rsp_valid. Legal range 1..7.
- ADDR_W, 32: byte-address width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wr  in  1  1 = write (SW), 0 = read (fetch/LW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data; 0 on writes and on errors.
- rsp_err  out  1  access was misaligned or out of range; qualified by rsp_valid.
- busy  out  1  request in flight (state != IDLE).

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - state = IDLE, latency counter = 0.
  - Outputs: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Storage contents are not cleared.
- Acceptance: a request is accepted on a rising edge where req_valid & req_ready. req_ready = 1 only in IDLE, so at most one request is outstanding.
- Address decode:
  - word index = req_addr[2 +: log2(DEPTH_WORDS)].
  - Out of range: any bit of req_addr[ADDR_W-1 : 2+log2(DEPTH_WORDS)] is set.
  - Misaligned: req_addr[1:0] != 0. Handling is set by the optional feature below.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE, accepted write:
    - Legal address: storage is updated at that edge.
    - Next state RESP. rsp_valid pulses in the following cycle, so write latency is 1.
    - Illegal address: storage is unchanged; RESP with rsp_err = 1.
  - IDLE, accepted read:
    - Address and error flag are latched; counter loads RD_LATENCY-1.
    - Next state RD_WAIT, or RESP directly if RD_LATENCY == 1.
  - RD_WAIT: counter decrements each cycle. At 0, go to RESP, with rsp_rdata = mem[latched index], or 0 with rsp_err = 1 for an illegal address.
  - RESP:
    - rsp_valid = 1 for exactly this cycle; next state is IDLE.
    - req_ready = 0 here, so the next acceptance is at the earliest one cycle after the pulse.
  - Total read latency: rsp_valid is high in cycle N + RD_LATENCY, where N is the acceptance edge.
- Data rules:
  - rsp_rdata and rsp_err are registered and held until the next RESP.
  - rsp_valid is 0 in every state other than RESP.
- Read-after-write: a read of a just-written word returns the new data. No bypass is needed because requests are serialised.
- req_valid while not ready: ignored; the requester must hold it.
- Request fields changing during RD_WAIT: no effect, because the address is latched.
- Reset mid-operation: the in-flight request is dropped and no rsp_valid is produced. A write already committed at its acceptance edge stays committed.

Optional Feature:
- Macro: MIPS_MEM_MISALIGN_TRAP_EN.
- Defined: misaligned addresses produce rsp_err = 1; reads return 0 and writes are suppressed.
- Undefined: req_addr[1:0] is ignored (forced word alignment), the access proceeds normally, and rsp_err reflects only out-of-range.

Decomposition:
- Package mips_mem_pkg:
  - state enum mem_state_t {IDLE, RD_WAIT, RESP}.
  - WORD_W = 32.
  - Default DEPTH_WORDS and RD_LATENCY.
  - Function word_index(addr).
- Sub-module mips_mem_array:
  - Single-port word storage, DEPTH_WORDS x 32.
  - Synchronous write with write enable; combinational read of the latched index.
- The top level holds the FSM, latency counter, address checks and response registers.

Test Plan:
- Reset mid-read: release Reset, then accept a read of 0x0; assert Reset 1 cycle later -> no rsp_valid ever, req_ready = 1 after release, busy = 0.
- Write then read: write 0xDEADBEEF to 0x10 -> rsp_valid 1 cycle after acceptance, err = 0. Read 0x10 -> rsp_valid exactly 2 cycles after acceptance, rdata = 0xDEADBEEF.
- Back-to-back with req_valid held high: req_ready drops during RD_WAIT/RESP. Second request is accepted the cycle after the first rsp_valid. rsp_valid is never high 2 cycles in a row.
- Out of range, DEPTH_WORDS = 256: write to 0x400 -> err = 1 and word 0 is unchanged. Read 0x400 -> err = 1, rdata = 0.
- Misaligned write 0x12345678 to 0x13:
  - MIPS_MEM_MISALIGN_TRAP_EN defined: err = 1, word 4 unchanged.
  - Undefined: err = 0; a read of 0x10 returns 0x12345678.
- RD_LATENCY = 1: a read of a written address gives rsp_valid 1 cycle after acceptance with correct data. No RD_WAIT cycle appears.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the multicycle MIPS memory responder.
package mips_mem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_DEPTH_WORDS = 256;
  localparam int unsigned DEF_RD_LATENCY  = 2;
  localparam int unsigned CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] rdata;
  } mem_rsp_t;

  // Word index taken from the byte address, masked to idx_w bits.
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'(1) << idx_w) - 64'(1);
    return 32'((addr >> 2) & mask);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the MIPS control FSM and the memory responder.
interface mips_mem_responder_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mips_mem_array.sv
// Single-port word storage: synchronous write, combinational read. Not reset.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: serialised fetch/LW/SW with fixed read latency.
// Optional MIPS_MEM_MISALIGN_TRAP_EN: misaligned accesses error out instead of being word-aligned.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
  parameter int unsigned ADDR_W      = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned HI_LSB = 2 + IDX_W;

  mem_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n, req_idx, arr_idx;
  logic              ill_q, ill_n, req_ill, oor;
  mem_rsp_t          rsp_q, rsp_n;
  logic              valid_q, valid_n;
  logic              ready_q, ready_n;
  logic              busy_q, busy_n;
  logic              mem_we;
  logic [WORD_W-1:0] arr_rdata;

  // Address decode of the incoming request.
  assign req_idx = IDX_W'(word_index(64'(bus.req_addr[ADDR_W-1:0]), IDX_W));
  assign oor     = (64'(bus.req_addr[ADDR_W-1:0]) >> HI_LSB) != 64'd0;

`ifdef MIPS_MEM_MISALIGN_TRAP_EN
  assign req_ill = oor | (bus.req_addr[1:0] != 2'b00);
`else
  assign req_ill = oor;
`endif

  // Writes only happen in IDLE, so the array port follows the live request there.
  assign arr_idx = (state == IDLE) ? req_idx : idx_q;

  mips_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .we      (mem_we),
    .idx     (arr_idx),
    .wdata   (bus.req_wdata),
    .rdata_c (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      ill_q   <= 1'b0;
      rsp_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx_q   <= idx_n;
      ill_q   <= ill_n;
      rsp_q   <= rsp_n;
      valid_q <= valid_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx_q;
    ill_n   = ill_q;
    rsp_n   = rsp_q;
    mem_we  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          if (bus.req_wr) begin
            mem_we     = !req_ill;
            rsp_n.err  = req_ill;
            rsp_n.rdata = '0;
            state_n    = RESP;
          end else begin
            idx_n = req_idx;
            ill_n = req_ill;
            cnt_n = CNT_W'(RD_LATENCY - 1);
            if (RD_LATENCY == 1) begin
              rsp_n.err   = req_ill;
              rsp_n.rdata = req_ill ? '0 : arr_rdata;
              state_n     = RESP;
            end else begin
              state_n = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          rsp_n.err   = ill_q;
          rsp_n.rdata = ill_q ? '0 : arr_rdata;
          state_n     = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    valid_n = (state_n == RESP);
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder against a word-array reference model.
module tb_mips_mem_responder;
  import mips_mem_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_mem_responder_if #(.ADDR_W(32)) bus  ();
  mips_mem_responder_if #(.ADDR_W(32)) bus1 ();

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int checks = 0;
  int passes = 0;

  logic [WORD_W-1:0] ref_mem   [DEPTH];
  bit                ref_known [DEPTH];

  function automatic bit exp_err(input logic [31:0] a);
    bit e;
    e = (a[31:10] != 22'd0);
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
    e = e | (a[1:0] != 2'b00);
`endif
    return e;
  endfunction

  // Reference behaviour: predicts the response and updates the model memory.
  function automatic void model(input bit wr, input logic [31:0] a, input logic [WORD_W-1:0] d,
                                output logic [WORD_W-1:0] erd, output bit eer,
                                output int elat, output bit known);
    int i;
    i     = int'(a[9:2]);
    eer   = exp_err(a);
    elat  = wr ? 1 : int'(LAT);
    erd   = '0;
    known = 1'b1;
    if (wr) begin
      if (!eer) begin
        ref_mem[i]   = d;
        ref_known[i] = 1'b1;
      end
    end else if (!eer) begin
      erd   = ref_mem[i];
      known = ref_known[i];
    end
  endfunction

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [WORD_W-1:0] d,
                        output logic [WORD_W-1:0] rd, output logic er, output int lat);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    if (bus.req_ready === 1'b1) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (bus.rsp_valid !== 1'b1 && lat < 20);
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err, bus.rsp_rdata} !== {4'b1000, 32'h0}) begin
      $display("FAIL reset_values got rdy=%b vld=%b busy=%b err=%b rdata=%h want 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err, bus.rsp_rdata);
    end else passes++;
  endtask

  task automatic test_reset_mid_read;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 32'h0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.busy, bus.rsp_valid} !== 3'b100) begin
      $display("FAIL reset_mid_read_state got rdy=%b busy=%b vld=%b want 1 0 0",
               bus.req_ready, bus.busy, bus.rsp_valid);
    end else passes++;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL reset_mid_read_pulse got rsp_valid seen=%b want 0", seen);
    else passes++;
  endtask

  task automatic test_write_read;
    logic [WORD_W-1:0] rd, erd;
    logic er;
    bit eer, kn;
    int lat, elat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    model(1'b1, 32'h10, 32'hDEADBEEF, erd, eer, elat, kn);
    checks++;
    if (lat !== 1 || er !== 1'b0) $display("FAIL wr_0x10 got lat=%0d err=%b want lat=1 err=0", lat, er);
    else passes++;
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    model(1'b0, 32'h10, 32'h0, erd, eer, elat, kn);
    checks++;
    if (lat !== int'(LAT)) $display("FAIL rd_0x10_lat got %0d want %0d", lat, LAT);
    else passes++;
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL rd_0x10_data got %h err=%b want deadbeef err=0", rd, er);
    else passes++;
  endtask

  task automatic test_out_of_range;
    logic [WORD_W-1:0] rd, erd;
    logic er;
    bit eer, kn;
    int lat, elat;
    do_req(1'b1, 32'h0, 32'hA5A50001, rd, er, lat);
    model(1'b1, 32'h0, 32'hA5A50001, erd, eer, elat, kn);
    do_req(1'b1, 32'h400, 32'h0BADF00D, rd, er, lat);
    model(1'b1, 32'h400, 32'h0BADF00D, erd, eer, elat, kn);
    checks++;
    if (lat !== 1 || er !== 1'b1) $display("FAIL oor_wr got lat=%0d err=%b want lat=1 err=1", lat, er);
    else passes++;
    do_req(1'b0, 32'h0, 32'h0, rd, er, lat);
    model(1'b0, 32'h0, 32'h0, erd, eer, elat, kn);
    checks++;
    if (rd !== 32'hA5A50001 || er !== 1'b0) $display("FAIL oor_word0_kept got %h err=%b want a5a50001 err=0", rd, er);
    else passes++;
    do_req(1'b0, 32'h400, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== int'(LAT))
      $display("FAIL oor_rd got rdata=%h err=%b lat=%0d want 0 1 %0d", rd, er, lat, LAT);
    else passes++;
  endtask

  task automatic test_misaligned;
    logic [WORD_W-1:0] rd, erd;
    logic er;
    bit eer, kn;
    int lat, elat;
    do_req(1'b1, 32'h13, 32'h12345678, rd, er, lat);
    model(1'b1, 32'h13, 32'h12345678, erd, eer, elat, kn);
    checks++;
    if (er !== eer || lat !== 1) $display("FAIL misal_wr got err=%b lat=%0d want err=%b lat=1", er, lat, eer);
    else passes++;
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    model(1'b0, 32'h10, 32'h0, erd, eer, elat, kn);
    checks++;
    if (rd !== erd || er !== 1'b0) $display("FAIL misal_word4 got %h err=%b want %h err=0", rd, er, erd);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [WORD_W-1:0] d, erd;
    bit eer, kn, rdy_seen;
    int lat, elat;
    d = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = d;
    model(1'b1, 32'h40, d, erd, eer, elat, kn);
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL b2b_first_ready got %b want 1", bus.req_ready);
    else passes++;
    @(posedge clk);
    #1 bus.req_wr = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b10) $display("FAIL b2b_resp got vld,rdy=%b%b want 10", bus.rsp_valid, bus.req_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) $display("FAIL b2b_reaccept got vld,rdy=%b%b want 01", bus.rsp_valid, bus.req_ready);
    else passes++;
    @(posedge clk);
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.req_ready !== 1'b0) rdy_seen = 1'b1;
    end while (bus.rsp_valid !== 1'b1 && lat < 20);
    model(1'b0, 32'h40, 32'h0, erd, eer, elat, kn);
    checks++;
    if (lat !== elat || bus.rsp_rdata !== erd || rdy_seen !== 1'b0)
      $display("FAIL b2b_read got lat=%0d rdata=%h rdy_seen=%b want %0d %h 0", lat, bus.rsp_rdata, rdy_seen, elat, erd);
    else passes++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_no_double got rsp_valid=%b want 0", bus.rsp_valid);
    else passes++;
  endtask

  task automatic test_lat1;
    logic [WORD_W-1:0] d;
    d = $urandom;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_wr    = 1'b1;
    bus1.req_addr  = 32'h20;
    bus1.req_wdata = d;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.rsp_valid, bus1.rsp_err} !== 2'b10) $display("FAIL lat1_wr got vld,err=%b%b want 10", bus1.rsp_valid, bus1.rsp_err);
    else passes++;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_wr    = 1'b0;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== d || bus1.rsp_err !== 1'b0)
      $display("FAIL lat1_rd got vld=%b rdata=%h err=%b want 1 %h 0", bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err, d);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus1.rsp_valid, bus1.req_ready, bus1.busy} !== 3'b010)
      $display("FAIL lat1_idle got vld,rdy,busy=%b%b%b want 010", bus1.rsp_valid, bus1.req_ready, bus1.busy);
    else passes++;
  endtask

  task automatic test_random;
    logic [WORD_W-1:0] rd, erd, d;
    logic [31:0] a;
    logic er;
    bit eer, kn, wr;
    int lat, elat, sel;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      wr  = 1'($urandom);
      d   = $urandom;
      a   = {22'd0, 8'($urandom), 2'b00};
      if (sel == 0) a = $urandom | 32'h400;
      else if (sel == 1) a[1:0] = 2'($urandom_range(1, 3));
      do_req(wr, a, d, rd, er, lat);
      model(wr, a, d, erd, eer, elat, kn);
      checks++;
      if (lat !== elat || er !== eer)
        $display("FAIL rand_%0d wr=%b a=%h got lat=%0d err=%b want lat=%0d err=%b", n, wr, a, lat, er, elat, eer);
      else passes++;
      if (kn) begin
        checks++;
        if (rd !== erd) $display("FAIL rand_data_%0d wr=%b a=%h got %h want %h", n, wr, a, rd, erd);
        else passes++;
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus1.req_valid = 1'b0;
    bus1.req_wr    = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_known[i] = 1'b0;
    test_reset;
    test_reset_mid_read;
    test_write_read;
    test_out_of_range;
    test_misaligned;
    test_back_to_back;
    test_lat1;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
